// File: rtl/quiz_game_fsm.sv
// Quiz game sequencer: loads questions, times the answer window, scores
// answers, holds a feedback state per question and ends the game after
// the last question.
module quiz_game_fsm #(
  parameter int unsigned NUM_QUESTIONS  = 10,
  parameter int unsigned TIME_LIMIT     = 15,
  parameter int unsigned FEEDBACK_TICKS = 2,
  parameter int unsigned TICK_DIV       = 50000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       ans_valid,
  input  logic       ans_correct,
  output logic [2:0] fsm_state,
  output logic [3:0] question_idx,
  output logic [7:0] score,
  output logic [4:0] time_left,
  output logic       next_q
);

  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_Q    = 3'd1,
    S_WAIT_ANS  = 3'd2,
    S_CORRECT   = 3'd3,
    S_WRONG     = 3'd4,
    S_TIMEOUT   = 3'd5,
    S_GAME_OVER = 3'd6
  } state_e;

  logic [2:0]       state_q, state_d;
  logic [3:0]       qidx_q, qidx_d;
  logic [7:0]       score_q, score_d;
  logic [4:0]       tl_q, tl_d;
  logic [3:0]       fb_q, fb_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             next_q_q, next_q_d;
  logic             tick;
  logic             timed_entry;

  // One-second tick at the divider's terminal count.
  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      qidx_q   <= 4'd0;
      score_q  <= 8'd0;
      tl_q     <= 5'd0;
      fb_q     <= 4'd0;
      div_q    <= '0;
      next_q_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qidx_q   <= qidx_d;
      score_q  <= score_d;
      tl_q     <= tl_d;
      fb_q     <= fb_d;
      div_q    <= div_d;
      next_q_q <= next_q_d;
    end
  end

  // Next-state, counters and registered pulse generation.
  always_comb begin
    state_d     = state_q;
    qidx_d      = qidx_q;
    score_d     = score_q;
    tl_d        = tl_q;
    fb_d        = fb_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    timed_entry = 1'b0;

    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start) begin
          score_d = 8'd0;
          qidx_d  = 4'd0;
          state_d = S_LOAD_Q;
        end
      end
      S_LOAD_Q: begin
        tl_d    = 5'(TIME_LIMIT);
        state_d = S_WAIT_ANS;
      end
      S_WAIT_ANS: begin
        // An answer takes priority over a coincident tick.
        if (ans_valid) begin
          if (ans_correct) begin
            state_d = S_CORRECT;
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end else begin
            state_d = S_WRONG;
          end
        end else if (tick) begin
          if (tl_q > 5'd1) begin
            tl_d = tl_q - 5'd1;
          end else begin
            tl_d    = 5'd0;
            state_d = S_TIMEOUT;
          end
        end
      end
      S_CORRECT, S_WRONG, S_TIMEOUT: begin
        if (tick) begin
          if (fb_q == 4'(FEEDBACK_TICKS - 1)) begin
            fb_d = 4'd0;
            if (qidx_q == 4'(NUM_QUESTIONS - 1)) begin
              state_d = S_GAME_OVER;
            end else begin
              qidx_d  = qidx_q + 4'd1;
              state_d = S_LOAD_Q;
            end
          end else begin
            fb_d = fb_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Timed states always start with a fresh divider and feedback count.
    if (state_d != state_q) begin
      timed_entry = (state_d == S_WAIT_ANS) || (state_d == S_CORRECT) ||
                    (state_d == S_WRONG)    || (state_d == S_TIMEOUT);
    end
    if (timed_entry) begin
      div_d = '0;
      fb_d  = 4'd0;
    end
  end

  // Question-load pulse is registered so it coincides with the LOAD_Q cycle.
  assign next_q_d = (state_d == S_LOAD_Q);

  assign fsm_state    = state_q;
  assign question_idx = qidx_q;
  assign score        = score_q;
  assign time_left    = tl_q;
  assign next_q       = next_q_q;

endmodule

// File: tb/tb_quiz_game_fsm.sv
// Directed bench for quiz_game_fsm with a short tick divider.
module tb_quiz_game_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       ans_valid;
  logic       ans_correct;
  logic [2:0] fsm_state;
  logic [3:0] question_idx;
  logic [7:0] score;
  logic [4:0] time_left;
  logic       next_q;

  int checks = 0;
  int errors = 0;

  quiz_game_fsm #(
    .NUM_QUESTIONS (2),
    .TIME_LIMIT    (3),
    .FEEDBACK_TICKS(1),
    .TICK_DIV      (4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .ans_valid   (ans_valid),
    .ans_correct (ans_correct),
    .fsm_state   (fsm_state),
    .question_idx(question_idx),
    .score       (score),
    .time_left   (time_left),
    .next_q      (next_q)
  );

  always #5 clk = ~clk;

  // Advance n clock cycles; returns at a falling edge (mid-cycle).
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({fsm_state, question_idx, score, time_left, next_q} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%0d q=%0d sc=%0d tl=%0d nq=%0d, want all 0",
               fsm_state, question_idx, score, time_left, next_q);
    end
    step(1);
    reset_n = 1'b1;
    step(2);
    checks++;
    if (fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL idle_hold: got st=%0d, want 0", fsm_state);
    end
  endtask

  // Correct answer on question 0, then a wrong answer on question 1 ending the game.
  task automatic test_correct_then_wrong();
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (fsm_state !== 3'd1 || next_q !== 1'b1 || question_idx !== 4'd0 || score !== 8'd0) begin
      errors++;
      $display("FAIL load_q0: got st=%0d nq=%0d q=%0d sc=%0d, want 1 1 0 0",
               fsm_state, next_q, question_idx, score);
    end
    step(1);
    checks++;
    if (fsm_state !== 3'd2 || time_left !== 5'd3 || next_q !== 1'b0) begin
      errors++;
      $display("FAIL wait_q0: got st=%0d tl=%0d nq=%0d, want 2 3 0", fsm_state, time_left, next_q);
    end
    step(1);
    ans_valid = 1'b1; ans_correct = 1'b1;
    step(1);
    ans_valid = 1'b0; ans_correct = 1'b0;
    checks++;
    if (fsm_state !== 3'd3 || score !== 8'd1 || time_left !== 5'd3) begin
      errors++;
      $display("FAIL correct: got st=%0d sc=%0d tl=%0d, want 3 1 3", fsm_state, score, time_left);
    end
    step(3);
    checks++;
    if (fsm_state !== 3'd3) begin
      errors++;
      $display("FAIL correct_hold: got st=%0d, want 3", fsm_state);
    end
    step(1);
    checks++;
    if (fsm_state !== 3'd1 || question_idx !== 4'd1 || next_q !== 1'b1) begin
      errors++;
      $display("FAIL load_q1: got st=%0d q=%0d nq=%0d, want 1 1 1", fsm_state, question_idx, next_q);
    end
    step(1);
    ans_valid = 1'b1; ans_correct = 1'b0;
    step(1);
    checks++;
    if (fsm_state !== 3'd4 || score !== 8'd1) begin
      errors++;
      $display("FAIL wrong: got st=%0d sc=%0d, want 4 1", fsm_state, score);
    end
    // A correct answer presented during feedback must be ignored.
    ans_correct = 1'b1;
    step(1);
    ans_valid = 1'b0; ans_correct = 1'b0;
    checks++;
    if (fsm_state !== 3'd4 || score !== 8'd1) begin
      errors++;
      $display("FAIL ans_in_feedback: got st=%0d sc=%0d, want 4 1", fsm_state, score);
    end
    step(3);
    checks++;
    if (fsm_state !== 3'd6 || score !== 8'd1 || question_idx !== 4'd1 || time_left !== 5'd3) begin
      errors++;
      $display("FAIL game_over: got st=%0d sc=%0d q=%0d tl=%0d, want 6 1 1 3",
               fsm_state, score, question_idx, time_left);
    end
    ans_valid = 1'b1; ans_correct = 1'b1;
    step(2);
    ans_valid = 1'b0; ans_correct = 1'b0;
    checks++;
    if (fsm_state !== 3'd6 || score !== 8'd1 || question_idx !== 4'd1) begin
      errors++;
      $display("FAIL ans_in_game_over: got st=%0d sc=%0d q=%0d, want 6 1 1",
               fsm_state, score, question_idx);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (fsm_state !== 3'd1 || score !== 8'd0 || question_idx !== 4'd0) begin
      errors++;
      $display("FAIL restart: got st=%0d sc=%0d q=%0d, want 1 0 0", fsm_state, score, question_idx);
    end
  endtask

  // Enters from LOAD_Q of question 0; lets the window expire.
  task automatic test_timeout();
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (fsm_state !== 3'd2 || time_left !== 5'd3 || question_idx !== 4'd0) begin
      errors++;
      $display("FAIL start_in_wait: got st=%0d tl=%0d q=%0d, want 2 3 0", fsm_state, time_left, question_idx);
    end
    step(3);
    checks++;
    if (time_left !== 5'd2) begin
      errors++;
      $display("FAIL tl_2: got %0d, want 2", time_left);
    end
    step(3);
    checks++;
    if (time_left !== 5'd2) begin
      errors++;
      $display("FAIL tl_2_hold: got %0d, want 2", time_left);
    end
    step(1);
    checks++;
    if (time_left !== 5'd1 || fsm_state !== 3'd2) begin
      errors++;
      $display("FAIL tl_1: got tl=%0d st=%0d, want 1 2", time_left, fsm_state);
    end
    step(4);
    checks++;
    if (time_left !== 5'd0 || fsm_state !== 3'd5) begin
      errors++;
      $display("FAIL timeout: got tl=%0d st=%0d, want 0 5", time_left, fsm_state);
    end
    step(3);
    checks++;
    if (fsm_state !== 3'd5 || time_left !== 5'd0) begin
      errors++;
      $display("FAIL timeout_hold: got st=%0d tl=%0d, want 5 0", fsm_state, time_left);
    end
    step(1);
    checks++;
    if (fsm_state !== 3'd1 || question_idx !== 4'd1 || next_q !== 1'b1 || score !== 8'd0) begin
      errors++;
      $display("FAIL after_timeout: got st=%0d q=%0d nq=%0d sc=%0d, want 1 1 1 0",
               fsm_state, question_idx, next_q, score);
    end
  endtask

  // Answer lands on the tick that would expire the window.
  task automatic test_simultaneous();
    step(1);
    step(8);
    checks++;
    if (time_left !== 5'd1 || fsm_state !== 3'd2) begin
      errors++;
      $display("FAIL sim_pre: got tl=%0d st=%0d, want 1 2", time_left, fsm_state);
    end
    step(3);
    ans_valid = 1'b1; ans_correct = 1'b1;
    step(1);
    ans_valid = 1'b0; ans_correct = 1'b0;
    checks++;
    if (fsm_state !== 3'd3 || time_left !== 5'd1 || score !== 8'd1) begin
      errors++;
      $display("FAIL simultaneous: got st=%0d tl=%0d sc=%0d, want 3 1 1", fsm_state, time_left, score);
    end
    step(4);
    checks++;
    if (fsm_state !== 3'd6 || question_idx !== 4'd1) begin
      errors++;
      $display("FAIL sim_game_over: got st=%0d q=%0d, want 6 1", fsm_state, question_idx);
    end
  endtask

  // Illegal code 7 must recover to IDLE on the next clock.
  task automatic test_illegal();
    force dut.state_q = 3'd7;
    #1;
    checks++;
    if (fsm_state !== 3'd7) begin
      errors++;
      $display("FAIL illegal_forced: got st=%0d, want 7", fsm_state);
    end
    release dut.state_q;
    step(1);
    checks++;
    if (fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL illegal_recover: got st=%0d, want 0", fsm_state);
    end
  endtask

  // Asynchronous reset during WAIT_ANS with a nonzero score.
  task automatic test_reset_mid();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    ans_valid = 1'b1; ans_correct = 1'b1;
    step(1);
    ans_valid = 1'b0; ans_correct = 1'b0;
    step(5);
    checks++;
    if (fsm_state !== 3'd2 || score !== 8'd1 || question_idx !== 4'd1) begin
      errors++;
      $display("FAIL pre_reset: got st=%0d sc=%0d q=%0d, want 2 1 1", fsm_state, score, question_idx);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({fsm_state, question_idx, score, time_left, next_q} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got st=%0d q=%0d sc=%0d tl=%0d nq=%0d, want all 0",
               fsm_state, question_idx, score, time_left, next_q);
    end
    step(2);
    reset_n = 1'b1;
    ans_valid = 1'b1; ans_correct = 1'b1;
    step(6);
    ans_valid = 1'b0; ans_correct = 1'b0;
    checks++;
    if (fsm_state !== 3'd0 || score !== 8'd0 || question_idx !== 4'd0 || time_left !== 5'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got st=%0d sc=%0d q=%0d tl=%0d, want 0 0 0 0",
               fsm_state, score, question_idx, time_left);
    end
    start = 1'b1;
    step(1);
    start = 1'b0;
    checks++;
    if (fsm_state !== 3'd1 || next_q !== 1'b1) begin
      errors++;
      $display("FAIL start_after_reset: got st=%0d nq=%0d, want 1 1", fsm_state, next_q);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    ans_valid   = 1'b0;
    ans_correct = 1'b0;
    test_reset();
    test_correct_then_wrong();
    test_timeout();
    test_simultaneous();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quiz_game_fsm.md
QUIZ_GAME_FSM -- requirements
Module: quiz_game_fsm

Interface
REQ-001 Parameter NUM_QUESTIONS, default 10, questions per game (range 1..15).
REQ-002 Parameter TIME_LIMIT, default 15, answer window in seconds (range 1..31).
REQ-003 Parameter FEEDBACK_TICKS, default 2, seconds each result state is held (range 1..15).
REQ-004 Parameter TICK_DIV, default 50000000, clk cycles per one-second tick (minimum 2).
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  single-cycle start pulse, already debounced.
REQ-008 ans_valid  input  1  single-cycle pulse: player submitted an answer.
REQ-009 ans_correct  input  1  answer correctness, qualified by ans_valid.
REQ-010 fsm_state  output  3  current state encoding; feeds the 3-bit state PIO.
REQ-011 question_idx  output  4  zero-based index of the current question.
REQ-012 score  output  8  count of correct answers this game.
REQ-013 time_left  output  5  seconds remaining in the answer window.
REQ-014 next_q  output  1  one-cycle pulse: software loads question question_idx.

Function
REQ-015 Encoding SHALL be: IDLE=0, LOAD_Q=1, WAIT_ANS=2, CORRECT=3, WRONG=4, TIMEOUT=5, GAME_OVER=6; code 7 SHALL go to IDLE on the next clock.
REQ-016 All outputs SHALL be registered; fsm_state SHALL equal the state register with zero added latency.
REQ-017 Tick divider SHALL count 0..TICK_DIV-1 and emit a one-cycle tick at terminal count.
  - Divider clears to 0 on every entry to WAIT_ANS, CORRECT, WRONG or TIMEOUT.
  - First tick after entry therefore arrives exactly TICK_DIV cycles later.
REQ-018 IDLE: start SHALL clear score and question_idx to 0 and go to LOAD_Q; other inputs ignored.
REQ-019 LOAD_Q SHALL last exactly one cycle:
  - next_q asserts for that cycle.
  - time_left loads TIME_LIMIT.
  - Next state is WAIT_ANS.
REQ-020 WAIT_ANS, ans_valid=1 and ans_correct=1: go to CORRECT; score increments, saturating at 255.
REQ-021 WAIT_ANS, ans_valid=1 and ans_correct=0: go to WRONG; score unchanged.
REQ-022 WAIT_ANS, tick with no ans_valid:
  - time_left>1: time_left decrements.
  - time_left=1: time_left becomes 0 and state goes to TIMEOUT.
REQ-023 ans_valid coincident with any tick in WAIT_ANS:
  - Answer wins.
  - time_left is not decremented that cycle.
REQ-024 CORRECT/WRONG/TIMEOUT SHALL hold for FEEDBACK_TICKS ticks, then:
  - question_idx = NUM_QUESTIONS-1: go to GAME_OVER.
  - Otherwise: question_idx increments and state goes to LOAD_Q.
REQ-025 time_left SHALL be frozen in all states except LOAD_Q and WAIT_ANS.
REQ-026 ans_valid outside WAIT_ANS SHALL be ignored, with no score or state change.
REQ-027 GAME_OVER: score and question_idx SHALL hold; start SHALL clear score and question_idx and go to LOAD_Q.
REQ-028 start in LOAD_Q, WAIT_ANS, CORRECT, WRONG or TIMEOUT SHALL be ignored.

Reset
REQ-029 reset_n=0 SHALL immediately force state IDLE and clear all registers, independent of clk:
  - fsm_state=0, question_idx=0, score=0, time_left=0, next_q=0, divider=0.
REQ-030 Reset asserted mid-game SHALL abandon the game with no residual state.
  - After reset_n deasserts, the block waits in IDLE for start.

Verification (TICK_DIV=4, TIME_LIMIT=3, FEEDBACK_TICKS=1, NUM_QUESTIONS=2)
REQ-031 Correct answer: start, then ans_valid=1/ans_correct=1 two cycles into WAIT_ANS.
  - Expect fsm_state 1->2->3, score=1.
  - After 4 cycles: question_idx=1, fsm_state=1, next_q pulses.
REQ-032 Timeout: no answer after start.
  - Expect time_left 3,2,1,0 at 4-cycle spacing and fsm_state=5 on the cycle time_left reaches 0.
  - After 4 cycles: question_idx=1.
REQ-033 Full game: one correct answer, then one wrong answer.
  - Expect fsm_state 4 and then 6, with score=1 and question_idx=1 held.
  - A further start returns score=0, question_idx=0, fsm_state=1.
REQ-034 Simultaneous events: ans_valid/ans_correct=1 on the same cycle as the tick that would take time_left 1->0.
  - Expect fsm_state=3, time_left=1, score incremented.
REQ-035 Reset mid-operation: assert reset_n=0 in WAIT_ANS with score=1, between clock edges.
  - Expect all outputs 0 before the next edge; no transition until start.
REQ-036 Ignored inputs:
  - ans_valid in IDLE, CORRECT or GAME_OVER causes no change.
  - start in WAIT_ANS causes no change.
  - Forced illegal code 7 reaches IDLE in one clock.
